// File: rtl/csa_acc_pkg.sv
// Shared types, default widths and bit-level helpers for the carry-save accumulator.
package csa_acc_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Majority of three bits: the carry of a full adder.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// Combinational 3:2 carry-save row; carry is returned unshifted (weight of its own bit).
module csa_row_3to2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    // One full adder per bit position, no carry chain between them.
    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (z[i]),
            .s  (sum[i]),
            .co (carry[i])
        );
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .co(c1));
    half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .co(c2));

    // The two partial carries can never both be set, so OR gives maj(a,b,ci).
    assign co = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder primitive.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: redundant sum/carry state, one final carry-propagate add.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q;
    state_t              state_d;
    logic [ACC_W-1:0]    s_q;
    logic [ACC_W-1:0]    s_d;
    logic [ACC_W-1:0]    c_q;
    logic [ACC_W-1:0]    c_d;
    logic                ovf_q;
    logic                ovf_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                in_ready_d;
    logic                out_valid_d;
    logic [ACC_W-1:0]    out_sum_d;
    logic                out_ovf_d;
    logic [CNT_W-1:0]    out_count_d;

    logic [ACC_W-1:0]    x_ext;
    logic [ACC_W-1:0]    row_sum;
    logic [ACC_W-1:0]    row_carry;
    logic [ACC_W:0]      resolve_full;
    logic                accept;

    assign x_ext  = ACC_W'(in_data);
    assign accept = in_valid & in_ready;

    // Carry-save compression of the incoming operand into the running S/C pair.
    csa_row_3to2 #(.W(ACC_W)) u_row (
        .x     (s_q),
        .y     (c_q),
        .z     (x_ext),
        .sum   (row_sum),
        .carry (row_carry)
    );

    // Single carry-propagate add, keeping the carry-out as overflow evidence.
    assign resolve_full = (ACC_W + 1)'(s_q) + (ACC_W + 1)'(c_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output-register next values.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum;
        out_ovf_d   = out_ovf;
        out_count_d = out_count;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    s_d   = row_sum;
                    // Bit ACC_W-1 of the majority shifts out: it is exact overflow.
                    c_d   = {row_carry[ACC_W-2:0], 1'b0};
                    ovf_d = ovf_q | row_carry[ACC_W-1];
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d   = resolve_full[ACC_W-1:0];
                out_ovf_d   = ovf_q | resolve_full[ACC_W];
                out_count_d = cnt_q;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    // Datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            s_q       <= s_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_ovf   <= out_ovf_d;
            out_count <= out_count_d;
        end
    end

endmodule
